// File: rtl/alarm_fsm_if.sv
// Timer handshake between the alarm controller and the countdown timer.
// The controller issues start_timer with a 4-bit length and receives expired.
interface alarm_fsm_if;
    logic       start_timer;
    logic [3:0] value;
    logic       expired;

    modport master (output start_timer, output value, input expired);
    modport slave  (input start_timer, input value, output expired);
endinterface

// File: rtl/alarm_fsm.sv
// Anti-theft controller for the car alarm: arming/disarming FSM, time parameter
// storage, timer start requests, siren and status LED.
// Optional feature macro: ALARM_FUEL_PUMP_EN (fuel pump gated by hidden switch + brake).
module alarm_fsm #(
    parameter logic [25:0] BLINK_HI = 26'd52_000_000
) (
    input  logic        clk_104mhz,
    input  logic        rst_n,
    input  logic        ignition,
    input  logic        driver_door,
    input  logic        passenger_door,
    input  logic        reprogram,
    input  logic [1:0]  time_param_sel,
    input  logic [3:0]  time_value,
    input  logic        hidden_switch,
    input  logic        brake_pedal,
    alarm_fsm_if.master tmr,
    output logic        siren,
    output logic        status_indicator,
    output logic        fuel_power,
    output logic [2:0]  state_out
);

    typedef enum logic [2:0] {
        StArmed          = 3'd0,
        StTriggered      = 3'd1,
        StSoundAlarm     = 3'd2,
        StAlarmHold      = 3'd3,
        StDisarmed       = 3'd4,
        StWaitDriverOpen = 3'd5,
        StWaitDriverClose= 3'd6,
        StArmDelay       = 3'd7
    } state_e;

    // Parameter indices
    localparam int unsigned PArmDelay  = 0;
    localparam int unsigned PDriver    = 1;
    localparam int unsigned PPassenger = 2;
    localparam int unsigned PAlarmOn   = 3;

    state_e      state_q, state_d;
    logic        start_q, start_d;
    logic [3:0]  value_q, value_d;
    logic [3:0]  param_q [4];
    logic        siren_q;
    logic        led_q;
    logic [25:0] blink_cnt_q;
    logic        fuel_q;

    logic any_door;
    logic expired_ok;

    assign any_door = driver_door | passenger_door;
    // An expired seen while start is high belongs to the previous countdown.
    assign expired_ok = tmr.expired & ~start_q;

    // Next-state and timer-start decode; reprogram beats ignition beats doors beats expired.
    always_comb begin
        state_d = state_q;
        start_d = 1'b0;
        value_d = value_q;
        if (reprogram) begin
            state_d = StArmed;
        end else if (ignition) begin
            state_d = StDisarmed;
        end else begin
            unique case (state_q)
                StArmed: begin
                    if (driver_door) begin
                        state_d = StTriggered;
                        start_d = 1'b1;
                        value_d = param_q[PDriver];
                    end else if (passenger_door) begin
                        state_d = StTriggered;
                        start_d = 1'b1;
                        value_d = param_q[PPassenger];
                    end
                end
                StTriggered: begin
                    if (expired_ok) state_d = StSoundAlarm;
                end
                StSoundAlarm: begin
                    if (!any_door) begin
                        state_d = StAlarmHold;
                        start_d = 1'b1;
                        value_d = param_q[PAlarmOn];
                    end
                end
                StAlarmHold: begin
                    if (any_door) state_d = StSoundAlarm;
                    else if (expired_ok) state_d = StArmed;
                end
                StDisarmed: begin
                    state_d = StWaitDriverOpen;
                end
                StWaitDriverOpen: begin
                    if (driver_door) state_d = StWaitDriverClose;
                end
                StWaitDriverClose: begin
                    if (!driver_door) begin
                        state_d = StArmDelay;
                        start_d = 1'b1;
                        value_d = param_q[PArmDelay];
                    end
                end
                StArmDelay: begin
                    if (any_door) begin
                        start_d = 1'b1;
                        value_d = param_q[PArmDelay];
                    end else if (expired_ok) begin
                        state_d = StArmed;
                    end
                end
            endcase
        end
    end

    // State, timer request and siren registers.
    always_ff @(posedge clk_104mhz) begin
        if (!rst_n) begin
            state_q <= StArmed;
            start_q <= 1'b0;
            value_q <= 4'd0;
            siren_q <= 1'b0;
        end else begin
            state_q <= state_d;
            start_q <= start_d;
            value_q <= value_d;
            siren_q <= (state_d == StSoundAlarm) || (state_d == StAlarmHold);
        end
    end

    // Programmable time parameters.
    always_ff @(posedge clk_104mhz) begin
        if (!rst_n) begin
            param_q[PArmDelay]  <= 4'd6;
            param_q[PDriver]    <= 4'd8;
            param_q[PPassenger] <= 4'd15;
            param_q[PAlarmOn]   <= 4'd10;
        end else if (reprogram) begin
            param_q[time_param_sel] <= time_value;
        end
    end

    // Status LED: blinks in ARMED starting lit, steady on while alarmed, off otherwise.
    always_ff @(posedge clk_104mhz) begin
        if (!rst_n) begin
            led_q       <= 1'b1;
            blink_cnt_q <= 26'd0;
        end else if (state_d == StArmed) begin
            if (state_q != StArmed) begin
                led_q       <= 1'b1;
                blink_cnt_q <= 26'd0;
            end else if (blink_cnt_q == BLINK_HI - 26'd1) begin
                led_q       <= ~led_q;
                blink_cnt_q <= 26'd0;
            end else begin
                blink_cnt_q <= blink_cnt_q + 26'd1;
            end
        end else begin
            blink_cnt_q <= 26'd0;
            led_q       <= (state_d == StTriggered) || (state_d == StSoundAlarm) ||
                           (state_d == StAlarmHold);
        end
    end

`ifdef ALARM_FUEL_PUMP_EN
    // Fuel pump latches on with ignition + hidden switch + brake, drops with ignition.
    always_ff @(posedge clk_104mhz) begin
        if (!rst_n) begin
            fuel_q <= 1'b0;
        end else if (!ignition) begin
            fuel_q <= 1'b0;
        end else if (hidden_switch && brake_pedal) begin
            fuel_q <= 1'b1;
        end
    end
`else
    logic unused_inputs;
    assign unused_inputs = hidden_switch ^ brake_pedal;

    // Fuel pump simply follows ignition.
    always_ff @(posedge clk_104mhz) begin
        if (!rst_n) fuel_q <= 1'b0;
        else        fuel_q <= ignition;
    end
`endif

    assign tmr.start_timer   = start_q;
    assign tmr.value         = value_q;
    assign siren             = siren_q;
    assign status_indicator  = led_q;
    assign fuel_power        = fuel_q;
    assign state_out         = state_q;

endmodule

// File: doc/alarm_fsm.md
# alarm_fsm

Anti-theft controller for the car-alarm design. It sits directly upstream of the countdown timer: it issues the timer's `start_timer` pulse and 4-bit `value`, and consumes the timer's `expired` pulse. It holds the four programmable time parameters, drives the siren and status LED, and optionally gates fuel-pump power. All switch and sensor inputs arrive already synchronized and debounced.

## Interface
- `BLINK_HI`, default `26'd52_000_000`: clock cycles per status-LED toggle in ARMED (0.5 s at 104 MHz).
- `clk_104mhz` in 1: system clock, 104 MHz.
- `rst_n` in 1: synchronous, active-low reset.
- `ignition` in 1: ignition switch on.
- `driver_door` in 1: driver door open.
- `passenger_door` in 1: passenger door open.
- `reprogram` in 1: one-cycle pulse that writes a time parameter.
- `time_param_sel` in 2: parameter index; 0 ARM_DELAY, 1 DRIVER_DELAY, 2 PASSENGER_DELAY, 3 ALARM_ON.
- `time_value` in 4: value written on `reprogram`.
- `hidden_switch` in 1: fuel-pump enable switch.
- `brake_pedal` in 1: brake depressed.
- `expired` in 1: timer-expired pulse from the timer.
- `start_timer` out 1: one-cycle registered pulse to the timer.
- `value` out 4: timer length. Registered, and valid in the same cycle as `start_timer`.
- `siren` out 1: alarm sounding.
- `status_indicator` out 1: status LED.
- `fuel_power` out 1: fuel-pump power.
- `state_out` out 3: current state encoding.

## Operation
- State encodings:
  - ARMED = 0
  - TRIGGERED = 1
  - SOUND_ALARM = 2
  - ALARM_HOLD = 3
  - DISARMED = 4
  - WAIT_DRIVER_OPEN = 5
  - WAIT_DRIVER_CLOSE = 6
  - ARM_DELAY = 7
- Priority in every state: `reprogram` first, then `ignition`, then door events, then `expired`.
- ARMED:
  - `ignition` → DISARMED.
  - `driver_door` → TRIGGERED, start timer with DRIVER_DELAY.
  - `passenger_door` (driver door closed) → TRIGGERED, start timer with PASSENGER_DELAY.
- TRIGGERED:
  - `ignition` → DISARMED.
  - `expired` → SOUND_ALARM.
- SOUND_ALARM:
  - `ignition` → DISARMED.
  - Both doors closed → ALARM_HOLD, start timer with ALARM_ON.
- ALARM_HOLD:
  - `ignition` → DISARMED.
  - Any door open → SOUND_ALARM.
  - `expired` → ARMED.
- DISARMED: `ignition` low → WAIT_DRIVER_OPEN.
- WAIT_DRIVER_OPEN:
  - `ignition` → DISARMED.
  - `driver_door` → WAIT_DRIVER_CLOSE.
- WAIT_DRIVER_CLOSE:
  - `ignition` → DISARMED.
  - `driver_door` low → ARM_DELAY, start timer with ARM_DELAY.
- ARM_DELAY:
  - `ignition` → DISARMED.
  - Any door open → restart the timer with ARM_DELAY and stay in ARM_DELAY.
  - `expired` → ARMED.
- `reprogram`:
  - Writes `time_value` into the parameter selected by `time_param_sel`.
  - Forces ARMED with no `start_timer` pulse.
  - The new value applies from the next timer start; a countdown already running is unaffected.
- Parameter reset defaults: ARM_DELAY = 6, DRIVER_DELAY = 8, PASSENGER_DELAY = 15, ALARM_ON = 10.
- `siren` is 1 in SOUND_ALARM and ALARM_HOLD, and 0 in every other state.
- `status_indicator`:
  - ARMED: toggles every `BLINK_HI` cycles. The blink counter clears on entry to ARMED and the LED starts at 1.
  - TRIGGERED, SOUND_ALARM, ALARM_HOLD: steady 1.
  - All other states: 0.
- The FSM ignores `expired` in any cycle where `start_timer` is 1, because that pulse belongs to the previous countdown.
- An `expired` in a state that does not time (ARMED, SOUND_ALARM, DISARMED, WAIT_*) has no effect.

## Timing
- Reset values:
  - State = ARMED.
  - `start_timer` = 0, `value` = 0, `siren` = 0.
  - `status_indicator` = 1.
  - `fuel_power` = 0.
  - Parameters = defaults; blink counter = 0.
- All outputs are registered. `state_out`, `siren`, `start_timer` and `value` update on the clock edge that takes the transition, so there is one cycle of latency from the triggering input.
- `start_timer` is high for exactly one cycle per start. `value` holds its last value between starts.
- Reset mid-countdown: the FSM returns to ARMED. A stray `expired` that arrives afterwards is ignored, because ARMED does not time.
- Both doors open in ARMED in the same cycle: DRIVER_DELAY is used.
- Parameter value 0 is legal; the alarm sounds about 2 cycles after the trigger.

## Configuration
- `ALARM_FUEL_PUMP_EN` defined:
  - `fuel_power` is set when `ignition`, `hidden_switch` and `brake_pedal` are all 1 in the same cycle.
  - `fuel_power` clears in the cycle after `ignition` goes low.
  - `fuel_power` is independent of alarm state.
- `ALARM_FUEL_PUMP_EN` undefined:
  - `fuel_power` is a registered copy of `ignition`.
  - `hidden_switch` and `brake_pedal` are unused.

## Test plan
- Bench setup: `BLINK_HI` = 4, with a behavioural timer model that asserts `expired` N cycles after `start_timer`.
- Reset, then open the driver door: `start_timer` pulses once with `value` = 8, `state_out` = 1. After `expired`, `state_out` = 2 and `siren` = 1.
- In SOUND_ALARM, close both doors: `value` = 10 and `state_out` = 3. Reopen the passenger door before `expired`: back to 2 with `siren` still 1. Close doors and let the timer expire: `state_out` = 0 and `siren` = 0.
- Ignition on in ARMED, then off, then driver door open and close: `start_timer` fires with `value` = 6. Open a door in ARM_DELAY: a second pulse with `value` = 6. `expired` → ARMED, and the LED toggles every 4 cycles.
- `reprogram` with `time_param_sel` = 1 and `time_value` = 3 while in TRIGGERED: `state_out` = 0 and no pulse. The next driver-door trigger gives `value` = 3.
- Assert `expired` in the same cycle as a door-reopen restart in ARM_DELAY: `state_out` stays 7. Assert `rst_n` = 0 mid-TRIGGERED: ARMED, with all outputs at their reset values.
- With `ALARM_FUEL_PUMP_EN`, `ignition`, `hidden_switch` and `brake_pedal` = 1: `fuel_power` = 1. Drop `ignition`: `fuel_power` = 0.
